data_mem_ctrl: RTL and testbench

Parametrised, pipelined data memory for the RISC datapath. Replaces the fixed 8×16 register-file data memory and adds a request/response handshake, per-byte write enables, and a configurable read latency. It also zero-initialises its array after reset and flags out-of-range accesses. It sits between the MEM stage and the core's load/store path; every accepted request returns exactly one in-order response.

---
 rtl/data_mem_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Pipelined data memory with request/response handshake, byte enables and RD_LAT-cycle responses.
// Optional byte parity with a test-only injection input is enabled by defining DMEM_PARITY_EN.
module data_mem_ctrl #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
`ifdef DMEM_PARITY_EN
    input  logic                par_inj,
`endif
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               init_we;

    logic [IDX_W-1:0]   idx;
    logic               oor;
    logic               accept;
    logic               rd_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [NB-1:0]      wr_be;
    logic [DATA_W-1:0]  wr_data;
    logic [DATA_W-1:0]  rd_raw;
    logic [NB-1:0]      par_bad;

    logic               v0_q, rd0_q, oor0_q;
    logic               res_v, res_e;
    logic [DATA_W-1:0]  res_d;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state_q == S_RUN);
        init_we   = (state_q == S_INIT);
    end

    assign idx    = req_addr[IDX_W-1:0];
    assign accept = req_valid & req_ready;
    assign rd_en  = accept & ~req_we;

    generate
        if (ADDR_W > IDX_W) begin : g_oor
            assign oor = |req_addr[ADDR_W-1:IDX_W];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    // Single write port shared by the clearing walk and accepted in-range writes.
    always_comb begin
        wr_idx  = idx;
        wr_data = req_wdata;
        wr_be   = '0;
        if (init_we) begin
            wr_idx  = cnt_q;
            wr_data = '0;
            wr_be   = '1;
        end else if (accept && req_we && !oor) begin
            wr_be   = req_be;
        end
    end

    // One RAM per byte lane so byte enables map onto independent write ports.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    mem_q[wr_idx] <= wr_data[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_q <= mem_q[idx];
                end
            end
            assign rd_raw[gi*8 +: 8] = rd_q;

`ifdef DMEM_PARITY_EN
            logic par_mem_q [DEPTH];
            logic par_rd_q;

            // Injection flips the freshly computed byte-0 parity, so it needs byte 0 enabled.
            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    par_mem_q[wr_idx] <= (^wr_data[gi*8 +: 8]) ^ ((gi == 0) & ~init_we & par_inj);
                end
                if (rd_en) begin
                    par_rd_q <= par_mem_q[idx];
                end
            end
            assign par_bad[gi] = par_rd_q ^ (^rd_q);
`else
            assign par_bad[gi] = 1'b0;
`endif
        end
    endgenerate

    // Stage 0 runs alongside the RAM read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q   <= 1'b0;
            rd0_q  <= 1'b0;
            oor0_q <= 1'b0;
        end else begin
            v0_q   <= accept;
            rd0_q  <= accept & ~req_we & ~oor;
            oor0_q <= accept & oor;
        end
    end

    assign res_v = v0_q;
    assign res_d = rd0_q ? rd_raw : '0;
    assign res_e = oor0_q | (rd0_q & (|par_bad));

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rsp_valid = res_v;
            assign rsp_rdata = res_d;
            assign rsp_err   = res_e;
        end else begin : g_pipe
            logic [RD_LAT-2:0] pv_q;
            logic [RD_LAT-2:0] pe_q;
            logic [DATA_W-1:0] pd_q [RD_LAT-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv_q <= '0;
                    pe_q <= '0;
                    for (int s = 0; s < RD_LAT - 1; s++) begin
                        pd_q[s] <= '0;
                    end
                end else begin
                    pv_q[0] <= res_v;
                    pe_q[0] <= res_e;
                    pd_q[0] <= res_d;
                    for (int s = 1; s < RD_LAT - 1; s++) begin
                        pv_q[s] <= pv_q[s-1];
                        pe_q[s] <= pe_q[s-1];
                        pd_q[s] <= pd_q[s-1];
                    end
                end
            end

            assign rsp_valid = pv_q[RD_LAT-2];
            assign rsp_rdata = pd_q[RD_LAT-2];
            assign rsp_err   = pe_q[RD_LAT-2];
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl (DEPTH=8, RD_LAT=3) against an array/queue reference model.
module tb_data_mem_ctrl;

    localparam int DW  = 16;
    localparam int DEP = 8;
    localparam int AW  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [1:0]    req_be;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
`ifdef DMEM_PARITY_EN
    logic          par_inj;
`endif

    data_mem_ctrl #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .RD_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
`ifdef DMEM_PARITY_EN
        .par_inj   (par_inj),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] d;
        logic        e;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mdl [DEP];
`ifdef DMEM_PARITY_EN
    bit          pbad [DEP];
`endif
    int          n_vec = 0;
    int          n_err = 0;
    int          edge_n = 0;
    int          init_n = 0;
    bit          run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // Applies the currently driven inputs for one clock edge and checks outputs after it.
    task automatic tick();
        bit   acc;
        bit   oob;
        int   ix;
        exp_t ex;
        bit   exp_v;
        acc = !rst && run && req_valid;
        if (acc) begin
            ix  = int'(req_addr) % DEP;
            oob = (int'(req_addr) >= DEP);
            ex.due = edge_n + LAT;
            if (req_we) begin
                if (!oob) begin
                    for (int b = 0; b < 2; b++) begin
                        if (req_be[b]) mdl[ix][b*8 +: 8] = req_wdata[b*8 +: 8];
                    end
`ifdef DMEM_PARITY_EN
                    if (req_be[0]) pbad[ix] = par_inj;
`endif
                end
                ex.d = 16'h0;
                ex.e = oob;
            end else begin
                ex.d = oob ? 16'h0 : mdl[ix];
                ex.e = oob;
`ifdef DMEM_PARITY_EN
                if (!oob && pbad[ix]) ex.e = 1'b1;
`endif
            end
            q.push_back(ex);
        end
        @(posedge clk);
        edge_n++;
        if (rst) begin
            q.delete();
            run    = 0;
            init_n = 0;
            for (int i = 0; i < DEP; i++) begin
                mdl[i] = 16'h0;
`ifdef DMEM_PARITY_EN
                pbad[i] = 1'b0;
`endif
            end
        end else if (!run) begin
            init_n++;
            if (init_n == DEP) run = 1;
        end
        #1;
        check("req_ready", 32'(req_ready), 32'(run));
        exp_v = (q.size() > 0) && (q[0].due == edge_n);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            ex = q.pop_front();
            check("rsp_rdata", 32'(rsp_rdata), 32'(ex.d));
            check("rsp_err", 32'(rsp_err), 32'(ex.e));
            $display("rsp edge=%0d rdata=%h err=%b", edge_n, rsp_rdata, rsp_err);
        end else begin
            check("idle_rdata", 32'(rsp_rdata), 32'h0);
            check("idle_err", 32'(rsp_err), 32'h0);
        end
    endtask

    task automatic req(input bit v, input bit we, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] be);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    endtask

    task automatic init_window();
        // Requests presented during INIT must be ignored.
        for (int i = 0; i < DEP; i++) begin
            req(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, DEP - 1)), 16'($urandom), 2'b11);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEP; a++) req(1'b1, 1'b0, 16'(a), 16'h0, 2'b00);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
`ifdef DMEM_PARITY_EN
        par_inj = 1'b0;
`endif
        for (int i = 0; i < DEP; i++) mdl[i] = 16'h0;
        idle(3);
        rst = 1'b0;
        init_window();
        read_all();
        idle(LAT);

        req(1'b1, 1'b1, 16'd5, 16'hBEEF, 2'b11);
        req(1'b1, 1'b0, 16'd5, 16'h0, 2'b00);
        idle(LAT);

        req(1'b1, 1'b1, 16'd2, 16'h1234, 2'b11);
        req(1'b1, 1'b1, 16'd2, 16'hABCD, 2'b10);
        req(1'b1, 1'b0, 16'd2, 16'h0, 2'b00);
        req(1'b1, 1'b1, 16'd2, 16'hFFFF, 2'b00);
        req(1'b1, 1'b0, 16'd2, 16'h0, 2'b00);
        idle(LAT);

        req(1'b1, 1'b1, 16'd8, 16'h5555, 2'b11);
        req(1'b1, 1'b0, 16'd8, 16'h0, 2'b00);
        req(1'b1, 1'b0, 16'd0, 16'h0, 2'b00);
        req(1'b1, 1'b0, 16'h8007, 16'h0, 2'b00);
        req(1'b1, 1'b0, 16'd7, 16'h0, 2'b00);
        idle(LAT);

        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) req(1'b1, 1'b1, 16'($urandom_range(0, DEP - 1)), 16'($urandom), 2'b11);
            else            req(1'b1, 1'b0, req_addr, 16'h0, 2'b00);
        end
        idle(LAT);

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [15:0] a;
            r = $urandom_range(0, 15);
            a = (r < 12) ? 16'(r % DEP) : 16'($urandom);
            req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, 16'($urandom),
                2'($urandom_range(0, 3)));
        end
        idle(LAT);

        // Reset with two reads in flight.
        req(1'b1, 1'b0, 16'd1, 16'h0, 2'b00);
        req(1'b1, 1'b0, 16'd2, 16'h0, 2'b00);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);
        // Reset again part-way through INIT.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        init_window();
        read_all();
        idle(LAT);

`ifdef DMEM_PARITY_EN
        par_inj = 1'b1;
        req(1'b1, 1'b1, 16'd1, 16'h00FF, 2'b11);
        par_inj = 1'b0;
        req(1'b1, 1'b0, 16'd1, 16'h0, 2'b00);
        req(1'b1, 1'b1, 16'd1, 16'h00FF, 2'b11);
        req(1'b1, 1'b0, 16'd1, 16'h0, 2'b00);
        idle(LAT);
`endif

        idle(2);
        check("drain", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
